// File: rtl/axi2apb_pkg.sv
// Shared types and field layout for the AXI4Lite-to-APB4 bridge.
// Holds the APB master state encoding, command/response field helpers, pprot bits.
package axi2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } apb_state_e;

  localparam logic [2:0] PPROT_PRIV  = 3'b001;
  localparam logic [2:0] PPROT_NSEC  = 3'b010;
  localparam logic [2:0] PPROT_INSTR = 3'b100;
  localparam logic [2:0] PPROT_MASK  =
    PPROT_PRIV | PPROT_NSEC | PPROT_INSTR;

  // Command word, MSB..LSB: {write, prot, strb, wdata, addr}
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int cmd_wdata_lsb(input int aw);
    return aw;
  endfunction

  function automatic int cmd_strb_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int cmd_prot_lsb(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  function automatic int cmd_write_bit(input int aw, input int dw);
    return aw + dw + dw / 8 + 3;
  endfunction

  function automatic int cmd_w(input int aw, input int dw);
    return cmd_write_bit(aw, dw) + 1;
  endfunction

  // Response word: {slverr, rdata}
  function automatic int rsp_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase wait watchdog; built only with APB_TIMEOUT_EN.
// Ports: i_clk/i_rst, i_clr (restart), i_wait (ACCESS && !pready), o_expire.
module apb_wdog #(
  parameter int LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_wait,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_wait) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of earlier waiting ACCESS cycles,
  // so this fires on the LIMIT-th one.
  assign o_expire = i_wait && (r_cnt == LAST);

endmodule

// File: rtl/apb4_master_fsm.sv
// APB4 master stage: pops command words, runs one APB4 transfer each, pushes a response.
// Ports: pclk/prst, cmd FIFO read side, rsp FIFO write side, APB4 master bus, busy, timeout.
// Optional macro APB_TIMEOUT_EN adds an ACCESS watchdog (apb_wdog) driving timeout.
module apb4_master_fsm
  import axi2apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          pclk,
  input  logic                          prst,
  input  logic                          cmd_empty,
  output logic                          cmd_pop,
  input  logic [cmd_w(ADDR_W,DATA_W)-1:0] cmd_rdata,
  input  logic                          rsp_full,
  output logic                          rsp_push,
  output logic [rsp_w(DATA_W)-1:0]      rsp_wdata,
  output logic                          psel,
  output logic                          penable,
  output logic [ADDR_W-1:0]             paddr,
  output logic                          pwrite,
  output logic [DATA_W-1:0]             pwdata,
  output logic [strb_w(DATA_W)-1:0]     pstrb,
  output logic [2:0]                    pprot,
  input  logic [DATA_W-1:0]             prdata,
  input  logic                          pready,
  input  logic                          pslverr,
  output logic                          busy,
  output logic                          timeout
);

  localparam int SW    = strb_w(DATA_W);
  localparam int WD_LO = cmd_wdata_lsb(ADDR_W);
  localparam int SB_LO = cmd_strb_lsb(ADDR_W, DATA_W);
  localparam int PR_LO = cmd_prot_lsb(ADDR_W, DATA_W);
  localparam int WR_B  = cmd_write_bit(ADDR_W, DATA_W);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  apb_state_e          r_state;
  apb_state_e          w_next;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [SW-1:0]       r_pstrb;
  logic [2:0]          r_pprot;
  logic [DATA_W:0]     r_rsp;

  logic w_idle;
  logic w_fetch;
  logic w_setup;
  logic w_access;
  logic w_resp;
  logic w_done;
  logic w_expire;
  logic w_wr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_fetch  = (r_state == ST_FETCH);
  assign w_setup  = (r_state == ST_SETUP);
  assign w_access = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);
  assign w_done   = w_access && pready;
  assign w_wr     = cmd_rdata[WR_B];

`ifdef APB_TIMEOUT_EN
  apb_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (pclk),
    .i_rst    (prst),
    .i_clr    (w_fetch),
    .i_wait   (w_access && !pready),
    .o_expire (w_expire)
  );
  assign timeout = w_expire;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (!cmd_empty) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready || w_expire) w_next = ST_RESP;
      end
      ST_RESP:   if (!rsp_full) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state  <= ST_IDLE;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_pprot  <= '0;
      r_rsp    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch) begin
        r_paddr  <= cmd_rdata[ADDR_W-1:0];
        r_pwrite <= w_wr;
        r_pwdata <= cmd_rdata[WD_LO +: DATA_W];
        r_pstrb  <= w_wr ? cmd_rdata[SB_LO +: SW] : '0;
        r_pprot  <= cmd_rdata[PR_LO +: 3] & PPROT_MASK;
      end
      // A real pready wins over a same-cycle watchdog abort.
      if (w_done) begin
        r_rsp <= {pslverr, r_pwrite ? '0 : prdata};
      end else if (w_expire) begin
        r_rsp <= {1'b1, {DATA_W{1'b0}}};
      end
    end
  end

  // Handshakes are gated by prst so nothing leaks while reset is held.
  assign cmd_pop   = w_idle && !cmd_empty && !prst;
  assign rsp_push  = w_resp && !rsp_full && !prst;
  assign rsp_wdata = r_rsp;
  assign psel      = w_setup || w_access;
  assign penable   = w_access;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign pprot     = r_pprot;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_apb4_master_fsm.sv
// Directed self-checking bench for apb4_master_fsm.
// Timeout scenario runs only when APB_TIMEOUT_EN is defined.
module tb_apb4_master_fsm;
  import axi2apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = cmd_w(AW, DW);
  localparam int RW = rsp_w(DW);

  logic          pclk = 1'b0;
  logic          prst;
  logic          cmd_empty;
  logic          cmd_pop;
  logic [CW-1:0] cmd_rdata;
  logic          rsp_full;
  logic          rsp_push;
  logic [RW-1:0] rsp_wdata;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic          busy;
  logic          timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb4_master_fsm #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .cmd_empty (cmd_empty),
    .cmd_pop   (cmd_pop),
    .cmd_rdata (cmd_rdata),
    .rsp_full  (rsp_full),
    .rsp_push  (rsp_push),
    .rsp_wdata (rsp_wdata),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .busy      (busy),
    .timeout   (timeout)
  );

  function automatic logic [CW-1:0] mk(
    input logic        w,
    input logic [2:0]  p,
    input logic [3:0]  s,
    input logic [31:0] d,
    input logic [31:0] a
  );
    return {w, p, s, d, a};
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    prst      = 1'b1;
    cmd_empty = 1'b0;
    cmd_rdata = '0;
    rsp_full  = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    step();
    step();
    // reset state, FIFO non-empty but reset held
    chk("rst_pop", cmd_pop, 0);
    chk("rst_psel", psel, 0);
    chk("rst_pen", penable, 0);
    chk("rst_push", rsp_push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp", rsp_wdata, 0);
    chk("rst_to", timeout, 0);
    cmd_empty = 1'b1;
    step();
    prst = 1'b0;

    // 1: write, pready immediately
    cmd_rdata = mk(1'b1, 3'd0, 4'hF, 32'hDEADBEEF, 32'h40);
    cmd_empty = 1'b0;
    pready    = 1'b1;
    settle();
    chk("t1_pop0", cmd_pop, 1);
    step();
    cmd_empty = 1'b1;
    settle();
    chk("t1_fetch_pop", cmd_pop, 0);
    chk("t1_fetch_psel", psel, 0);
    chk("t1_fetch_busy", busy, 1);
    step();
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_pen", penable, 0);
    chk("t1_paddr", paddr, 32'h40);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 32'hDEADBEEF);
    chk("t1_pstrb", pstrb, 4'hF);
    step();
    chk("t1_acc_psel", psel, 1);
    chk("t1_acc_pen", penable, 1);
    chk("t1_acc_push", rsp_push, 0);
    step();
    chk("t1_resp_push", rsp_push, 1);
    chk("t1_resp_data", rsp_wdata, 0);
    chk("t1_resp_psel", psel, 0);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_push", rsp_push, 0);
    chk("t1_idle_paddr", paddr, 32'h40);
    chk("t1_idle_pwdata", pwdata, 32'hDEADBEEF);

    // 2: read with 3 wait cycles
    cmd_rdata = mk(1'b0, 3'd0, 4'hF, 32'h0, 32'h44);
    cmd_empty = 1'b0;
    pready    = 1'b0;
    prdata    = 32'h12345678;
    settle();
    chk("t2_pop", cmd_pop, 1);
    step();
    cmd_empty = 1'b1;
    step();
    chk("t2_setup_paddr", paddr, 32'h44);
    chk("t2_pwrite", pwrite, 0);
    chk("t2_pstrb", pstrb, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_wait_pen", penable, 1);
      chk("t2_wait_psel", psel, 1);
      chk("t2_wait_paddr", paddr, 32'h44);
      chk("t2_wait_push", rsp_push, 0);
    end
    step();
    pready = 1'b1;
    settle();
    chk("t2_rdy_pen", penable, 1);
    chk("t2_rdy_paddr", paddr, 32'h44);
    step();
    pready = 1'b0;
    chk("t2_push", rsp_push, 1);
    chk("t2_data", rsp_wdata, {1'b0, 32'h12345678});
    step();
    chk("t2_idle", busy, 0);

    // 3: read with slave error
    cmd_rdata = mk(1'b0, 3'b010, 4'h3, 32'h0, 32'h48);
    cmd_empty = 1'b0;
    prdata    = 32'hCAFEF00D;
    pslverr   = 1'b1;
    pready    = 1'b1;
    step();
    cmd_empty = 1'b1;
    step();
    chk("t3_pstrb", pstrb, 0);
    chk("t3_pprot", pprot, 3'b010);
    step();
    chk("t3_acc_pstrb", pstrb, 0);
    step();
    pslverr = 1'b0;
    chk("t3_push", rsp_push, 1);
    chk("t3_data", rsp_wdata, {1'b1, 32'hCAFEF00D});
    step();

    // 4: response FIFO full for 4 RESP cycles
    cmd_rdata = mk(1'b1, 3'b001, 4'h5, 32'hA5A5A5A5, 32'h50);
    cmd_empty = 1'b0;
    rsp_full  = 1'b1;
    pready    = 1'b1;
    step();
    chk("t4_fetch_pop", cmd_pop, 0);
    step();
    chk("t4_pstrb", pstrb, 4'h5);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_full_push", rsp_push, 0);
      chk("t4_full_busy", busy, 1);
      chk("t4_full_pop", cmd_pop, 0);
      chk("t4_full_psel", psel, 0);
    end
    step();
    rsp_full = 1'b0;
    settle();
    chk("t4_push", rsp_push, 1);
    chk("t4_data", rsp_wdata, 0);
    chk("t4_hold_pop", cmd_pop, 0);

    // 5: reset pulsed during ACCESS of the next command
    cmd_rdata = mk(1'b1, 3'd0, 4'hF, 32'h0BADF00D, 32'h60);
    step();
    chk("t5_pop", cmd_pop, 1);
    step();
    cmd_empty = 1'b1;
    pready    = 1'b0;
    step();
    step();
    chk("t5_acc_pen", penable, 1);
    prst = 1'b1;
    settle();
    chk("t5_rst_push", rsp_push, 0);
    step();
    chk("t5_psel", psel, 0);
    chk("t5_pen", penable, 0);
    chk("t5_busy", busy, 0);
    chk("t5_push", rsp_push, 0);
    chk("t5_paddr", paddr, 0);
    prst      = 1'b0;
    cmd_rdata = mk(1'b0, 3'd0, 4'h0, 32'h0, 32'h70);
    cmd_empty = 1'b0;
    prdata    = 32'h55AA55AA;
    pready    = 1'b1;
    settle();
    chk("t5_resume_pop", cmd_pop, 1);
    step();
    cmd_empty = 1'b1;
    step();
    chk("t5_r_paddr", paddr, 32'h70);
    step();
    step();
    chk("t5_r_push", rsp_push, 1);
    chk("t5_r_data", rsp_wdata, {1'b0, 32'h55AA55AA});
    step();

`ifdef APB_TIMEOUT_EN
    // 6: watchdog abort after 8 ACCESS cycles
    cmd_rdata = mk(1'b0, 3'd0, 4'h0, 32'h0, 32'h80);
    cmd_empty = 1'b0;
    pready    = 1'b0;
    prdata    = 32'hFFFFFFFF;
    step();
    cmd_empty = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t6_wait_to", timeout, 0);
      chk("t6_wait_pen", penable, 1);
    end
    step();
    chk("t6_to", timeout, 1);
    chk("t6_to_pen", penable, 1);
    step();
    chk("t6_to_clr", timeout, 0);
    chk("t6_push", rsp_push, 1);
    chk("t6_data", rsp_wdata, {1'b1, 32'h0});
    step();
    chk("t6_idle", busy, 0);
`else
    // without the watchdog a stalled ACCESS never ends
    cmd_rdata = mk(1'b0, 3'd0, 4'h0, 32'h0, 32'h80);
    cmd_empty = 1'b0;
    pready    = 1'b0;
    step();
    cmd_empty = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t6n_to", timeout, 0);
      chk("t6n_pen", penable, 1);
    end
    pready = 1'b1;
    prdata = 32'h0000ABCD;
    step();
    chk("t6n_push", rsp_push, 1);
    chk("t6n_data", rsp_wdata, {1'b0, 32'h0000ABCD});
    pready = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
